// File: rtl/motor_hbridge_drv_if.sv
// Signal bundle between the PWM/direction source (master) and one H-bridge drive stage (slave).
interface motor_hbridge_drv_if;
  logic       pwm_i;
  logic       dir_i;
  logic       en_i;
  logic       brake_i;
  logic       wdog_kick_i;
  logic [1:0] mt_o;
  logic       en_o;
  logic       dir_o;
  logic       busy_o;
  logic       fault_o;

  modport master (
    output pwm_i, dir_i, en_i, brake_i, wdog_kick_i,
    input  mt_o, en_o, dir_o, busy_o, fault_o
  );

  modport slave (
    input  pwm_i, dir_i, en_i, brake_i, wdog_kick_i,
    output mt_o, en_o, dir_o, busy_o, fault_o
  );
endinterface

// File: rtl/motor_hbridge_drv.sv
// Per-wheel H-bridge drive stage: registered PWM/direction outputs, dead-time coast, active brake.
// Optional command watchdog is compiled in when MT_WDOG_EN is defined.
module motor_hbridge_drv #(
  parameter int unsigned DEADTIME_CYC = 64,
  parameter int unsigned DT_W         = 8,
  parameter int unsigned WDOG_CYC     = 1474560,
  parameter int unsigned WD_W         = 21
) (
  input  logic               clk_sys,
  input  logic               rst_sys,
  motor_hbridge_drv_if.slave hb
);

  localparam logic [DT_W-1:0] DT_LAST = DT_W'(DEADTIME_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEADTIME = 2'd1,
    ST_DRIVE    = 2'd2,
    ST_BRAKE    = 2'd3
  } state_t;

  state_t          r_state;
  logic [1:0]      r_mt;
  logic            r_en;
  logic            r_dir;
  logic            r_busy;
  logic            r_dir_in;
  logic [DT_W-1:0] r_dt_cnt;
  logic            w_block;

  // The two bridge legs are always driven in anti-phase while driving.
  function automatic logic [1:0] drive_mt(input logic dir, input logic pwm);
    return dir ? {pwm, ~pwm} : {~pwm, pwm};
  endfunction

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      r_state  <= ST_IDLE;
      r_mt     <= 2'b00;
      r_en     <= 1'b0;
      r_dir    <= 1'b0;
      r_busy   <= 1'b0;
      r_dir_in <= 1'b0;
      r_dt_cnt <= '0;
    end else begin
      r_dir_in <= hb.dir_i;
      if (w_block || !hb.en_i) begin
        r_state  <= ST_IDLE;
        r_mt     <= 2'b00;
        r_en     <= 1'b0;
        r_busy   <= 1'b0;
        r_dt_cnt <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_en     <= 1'b1;
            r_dt_cnt <= '0;
            if (hb.brake_i) begin
              r_state <= ST_BRAKE;
              r_mt    <= 2'b11;
              r_busy  <= 1'b0;
            end else begin
              r_state <= ST_DEADTIME;
              r_mt    <= 2'b00;
              r_busy  <= 1'b1;
            end
          end

          ST_DEADTIME: begin
            r_en <= 1'b1;
            if (hb.brake_i) begin
              r_state  <= ST_BRAKE;
              r_mt     <= 2'b11;
              r_busy   <= 1'b0;
              r_dt_cnt <= '0;
            end else if (hb.dir_i != r_dir_in) begin
              // A bouncing direction request must see a full quiet coast window.
              r_mt     <= 2'b00;
              r_busy   <= 1'b1;
              r_dt_cnt <= '0;
            end else if (r_dt_cnt == DT_LAST) begin
              r_state  <= ST_DRIVE;
              r_dir    <= hb.dir_i;
              r_mt     <= drive_mt(hb.dir_i, hb.pwm_i);
              r_busy   <= 1'b0;
              r_dt_cnt <= '0;
            end else begin
              r_mt     <= 2'b00;
              r_busy   <= 1'b1;
              r_dt_cnt <= r_dt_cnt + 1'b1;
            end
          end

          ST_DRIVE: begin
            r_en     <= 1'b1;
            r_dt_cnt <= '0;
            if (hb.brake_i) begin
              r_state <= ST_BRAKE;
              r_mt    <= 2'b11;
              r_busy  <= 1'b0;
            end else if (hb.dir_i != r_dir) begin
              r_state <= ST_DEADTIME;
              r_mt    <= 2'b00;
              r_busy  <= 1'b1;
            end else begin
              r_mt    <= drive_mt(r_dir, hb.pwm_i);
              r_busy  <= 1'b0;
            end
          end

          ST_BRAKE: begin
            r_en     <= 1'b1;
            r_dt_cnt <= '0;
            if (hb.brake_i) begin
              r_mt   <= 2'b11;
              r_busy <= 1'b0;
            end else begin
              // Leaving brake always coasts first; the legs were both high.
              r_state <= ST_DEADTIME;
              r_mt    <= 2'b00;
              r_busy  <= 1'b1;
            end
          end

          default: begin
            r_state  <= ST_IDLE;
            r_mt     <= 2'b00;
            r_en     <= 1'b0;
            r_busy   <= 1'b0;
            r_dt_cnt <= '0;
          end
        endcase
      end
    end
  end

`ifdef MT_WDOG_EN
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYC - 1);

  logic [WD_W-1:0] r_wd_cnt;
  logic            r_fault;
  logic            r_en_prev;
  logic            w_wd_hit;

  assign w_wd_hit = hb.en_i & ~hb.wdog_kick_i & ~r_fault & (r_wd_cnt == WD_LAST);
  assign w_block  = r_fault | w_wd_hit;

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      r_wd_cnt  <= '0;
      r_fault   <= 1'b0;
      r_en_prev <= 1'b0;
    end else begin
      r_en_prev <= hb.en_i;
      if (!hb.en_i || hb.wdog_kick_i || r_fault || w_wd_hit) begin
        r_wd_cnt <= '0;
      end else begin
        r_wd_cnt <= r_wd_cnt + 1'b1;
      end
      // Only a deliberate disable (en falling edge) or reset acknowledges a timeout.
      if (r_en_prev && !hb.en_i) begin
        r_fault <= 1'b0;
      end else if (w_wd_hit) begin
        r_fault <= 1'b1;
      end
    end
  end

  assign hb.fault_o = r_fault;
`else
  logic [WD_W:0] w_unused_wd;
  assign w_unused_wd = {hb.wdog_kick_i, WD_W'(WDOG_CYC)};
  assign w_block     = 1'b0;
  assign hb.fault_o  = 1'b0;
`endif

  assign hb.mt_o   = r_mt;
  assign hb.en_o   = r_en;
  assign hb.dir_o  = r_dir;
  assign hb.busy_o = r_busy;

endmodule
